// File: rtl/epd_update_ctrl.sv
// E-paper panel update sequencer: powers the panel rails, runs clean and gray waveform frames
// against an external timing generator, then powers down and reports a completion status.
module epd_update_ctrl #(
    parameter int unsigned CLEAN_FRAMES  = 15,
    parameter int unsigned GRAY_FRAMES   = 12,
    parameter int unsigned PWR_SETTLE    = 2000,
    parameter int unsigned PWR_TIMEOUT   = 500000,
    parameter int unsigned FRAME_TIMEOUT = 200000,
    parameter int unsigned PWR_DN_WAIT   = 1000
) (
    input  logic       glb_clk,
    input  logic       glb_nrst,
    input  logic       req_valid,
    input  logic       req_mode,
    output logic       req_ready,
    input  logic       abort,
    output logic       pwr_en,
    input  logic       pwr_good,
    output logic       frame_start,
    input  logic       frame_done,
    output logic       frame_phase,
    output logic [3:0] frame_idx,
    output logic       busy,
    output logic       done,
    output logic [1:0] status
);

    localparam int unsigned SettleW   = $clog2(PWR_SETTLE) + 1;
    localparam int unsigned PtmoW     = $clog2(PWR_TIMEOUT) + 1;
    localparam int unsigned FtmoW     = $clog2(FRAME_TIMEOUT) + 1;
    localparam int unsigned DnW       = $clog2(PWR_DN_WAIT) + 1;
    localparam int unsigned MaxFrames = (CLEAN_FRAMES > GRAY_FRAMES) ? CLEAN_FRAMES : GRAY_FRAMES;
    localparam int unsigned IdxW      = $clog2(MaxFrames) + 1;

    localparam logic [1:0] StatOk       = 2'd0;
    localparam logic [1:0] StatAbort    = 2'd1;
    localparam logic [1:0] StatPwrTmo   = 2'd2;
    localparam logic [1:0] StatFrameErr = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StPwrUp,
        StCleanIssue,
        StCleanWait,
        StGrayIssue,
        StGrayWait,
        StPwrDn
    } state_e;

    state_e             state_q, state_d;
    logic               mode_q, mode_d;
    logic               abort_q, abort_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [PtmoW-1:0]   ptmo_q, ptmo_d;
    logic [FtmoW-1:0]   ftmo_q, ftmo_d;
    logic [DnW-1:0]     dn_q, dn_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [1:0]         status_q, status_d;

    logic req_ready_q, pwr_en_q, frame_start_q, frame_phase_q, busy_q, done_q;

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        abort_d  = abort_q;
        settle_d = settle_q;
        ptmo_d   = ptmo_q;
        ftmo_d   = '0;
        dn_d     = '0;
        idx_d    = idx_q;
        status_d = status_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    mode_d   = req_mode;
                    status_d = StatOk;
                    abort_d  = 1'b0;
                    settle_d = '0;
                    ptmo_d   = '0;
                    idx_d    = '0;
                    state_d  = StPwrUp;
                end
            end

            StPwrUp: begin
                settle_d = pwr_good ? settle_q + 1'b1 : '0;
                ptmo_d   = ptmo_q + 1'b1;
                if (abort) begin
                    status_d = StatAbort;
                    state_d  = StPwrDn;
                end else if (settle_d == SettleW'(PWR_SETTLE)) begin
                    if (mode_q) begin
                        idx_d   = IdxW'(CLEAN_FRAMES - 1);
                        state_d = StCleanIssue;
                    end else begin
                        idx_d   = '0;
                        state_d = StGrayIssue;
                    end
                end else if (ptmo_d == PtmoW'(PWR_TIMEOUT)) begin
                    status_d = StatPwrTmo;
                    state_d  = StPwrDn;
                end
            end

            StCleanIssue, StGrayIssue: begin
                // frame_done is deliberately not looked at while frame_start is high
                abort_d = abort_q | abort;
                if (!pwr_good) begin
                    status_d = StatFrameErr;
                    state_d  = StPwrDn;
                end else begin
                    state_d = (state_q == StCleanIssue) ? StCleanWait : StGrayWait;
                end
            end

            StCleanWait, StGrayWait: begin
                abort_d = abort_q | abort;
                ftmo_d  = ftmo_q + 1'b1;
                if (!pwr_good) begin
                    status_d = StatFrameErr;
                    state_d  = StPwrDn;
                end else if (ftmo_d == FtmoW'(FRAME_TIMEOUT)) begin
                    status_d = StatFrameErr;
                    state_d  = StPwrDn;
                end else if (frame_done) begin
                    if (abort_d) begin
                        status_d = StatAbort;
                        state_d  = StPwrDn;
                    end else if (state_q == StCleanWait) begin
                        if (idx_q == '0) begin
                            state_d = StGrayIssue;
                        end else begin
                            idx_d   = idx_q - 1'b1;
                            state_d = StCleanIssue;
                        end
                    end else if (idx_q == IdxW'(GRAY_FRAMES - 1)) begin
                        state_d = StPwrDn;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StGrayIssue;
                    end
                end
            end

            StPwrDn: begin
                abort_d = 1'b0;
                dn_d    = dn_q + 1'b1;
                if (dn_d == DnW'(PWR_DN_WAIT)) begin
                    dn_d    = '0;
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge glb_clk or negedge glb_nrst) begin
        if (!glb_nrst) begin
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            abort_q       <= 1'b0;
            settle_q      <= '0;
            ptmo_q        <= '0;
            ftmo_q        <= '0;
            dn_q          <= '0;
            idx_q         <= '0;
            status_q      <= StatOk;
            req_ready_q   <= 1'b1;
            pwr_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_phase_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            abort_q       <= abort_d;
            settle_q      <= settle_d;
            ptmo_q        <= ptmo_d;
            ftmo_q        <= ftmo_d;
            dn_q          <= dn_d;
            idx_q         <= idx_d;
            status_q      <= status_d;
            // Outputs are registered from the next state so they line up with state_q
            req_ready_q   <= (state_d == StIdle);
            pwr_en_q      <= (state_d != StIdle) && (state_d != StPwrDn);
            frame_start_q <= (state_d == StCleanIssue) || (state_d == StGrayIssue);
            frame_phase_q <= (state_d == StGrayIssue) || (state_d == StGrayWait);
            busy_q        <= (state_d != StIdle);
            done_q        <= (state_q == StPwrDn) && (state_d == StIdle);
        end
    end

    assign req_ready   = req_ready_q;
    assign pwr_en      = pwr_en_q;
    assign frame_start = frame_start_q;
    assign frame_phase = frame_phase_q;
    assign frame_idx   = 4'(idx_q);
    assign busy        = busy_q;
    assign done        = done_q;
    assign status      = status_q;

endmodule
